// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader.
// Holds the loader FSM states, the CRC polynomial and the byte-count helper.
package clb_cfg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StVerify,
      StDone
   } cfg_state_e;

   localparam logic [7:0]  CRC_POLY         = 8'h07;
   localparam int unsigned BITS_PER_CLB_DEF = 17;

   function automatic int unsigned words_for(input int unsigned len);
      return (len + 32'd7) / 32'd8;
   endfunction

endpackage

// File: rtl/clb_config_loader_if.sv
// Byte-stream, scan-chain and status signals of the CLB configuration loader.
// The master side feeds bytes and closes the chain; the slave side is the loader.
interface clb_cfg_if;

   logic       start;
   logic [7:0] word_in;
   logic       word_valid;
   logic       word_ready;
   logic       prog_in;
   logic       prog_en;
   logic       chain_out;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] crc_out;

   modport master (
      output start, word_in, word_valid, chain_out,
      input  word_ready, prog_in, prog_en, busy, done, error, crc_out
   );

   modport slave (
      input  start, word_in, word_valid, chain_out,
      output word_ready, prog_in, prog_en, busy, done, error, crc_out
   );

endinterface

// File: rtl/clb_config_loader_crc8.sv
// Bit-serial CRC-8 accumulator, polynomial CRC_POLY, initial value zero.
// A clear takes priority over a fold in the same cycle.
module crc8_serial
   import clb_cfg_pkg::*;
(
   input  logic       prog_clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         r_crc <= 8'h00;
      end else if (i_clr) begin
         r_crc <= 8'h00;
      end else if (i_en) begin
         r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ i_bit) ? CRC_POLY : 8'h00);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/clb_config_loader.sv
// Serializes configuration bytes into a chain of cascaded CLBs, then recirculates
// the chain once and compares the read-back CRC-8 against the load CRC-8.
module clb_config_loader
   import clb_cfg_pkg::*;
#(
   parameter int unsigned NUM_CLBS     = 4,
   parameter int unsigned BITS_PER_CLB = BITS_PER_CLB_DEF
) (
   input logic      prog_clk,
   input logic      rst,
   clb_cfg_if.slave io_cfg
);

   localparam int unsigned CHAIN_LEN = NUM_CLBS * BITS_PER_CLB;
   localparam int unsigned NUM_WORDS = words_for(CHAIN_LEN);
   localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int unsigned WC_W      = $clog2(NUM_WORDS + 1);

   cfg_state_e       r_state, w_state_d;
   logic [7:0]       r_shift, w_shift_d;
   logic [3:0]       r_bits_left, w_bits_left_d;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_d;
   logic [CNT_W-1:0] r_ver_cnt, w_ver_cnt_d;
   logic [WC_W-1:0]  r_word_cnt, w_word_cnt_d;
   logic             r_prog_in, w_prog_in_d;
   logic             r_prog_en, w_prog_en_d;
   logic             r_recirc, w_recirc_d;
   logic             r_word_ready, w_word_ready_d;
   logic             r_busy, w_busy_d;
   logic             r_done, w_done_d;
   logic             r_error, w_error_d;
   logic             w_hs, w_crc_clr, w_load_en, w_ver_en;
   logic [CNT_W-1:0] w_bits_need;
   logic [7:0]       w_crc_load, w_crc_ver;

   always_comb begin
      w_state_d      = r_state;
      w_shift_d      = r_shift;
      w_bits_left_d  = r_bits_left;
      w_bit_cnt_d    = r_bit_cnt;
      w_ver_cnt_d    = r_ver_cnt;
      w_word_cnt_d   = r_word_cnt;
      w_prog_in_d    = r_prog_in;
      w_prog_en_d    = 1'b0;
      w_recirc_d     = 1'b0;
      w_done_d       = 1'b0;
      w_error_d      = r_error;
      w_crc_clr      = 1'b0;
      w_load_en      = 1'b0;
      w_ver_en       = 1'b0;
      w_hs           = r_word_ready && io_cfg.word_valid;

      unique case (r_state)
         StIdle: begin
            if (io_cfg.start) begin
               w_state_d     = StLoad;
               w_crc_clr     = 1'b1;
               w_error_d     = 1'b0;
               w_bit_cnt_d   = '0;
               w_ver_cnt_d   = '0;
               w_word_cnt_d  = '0;
               w_bits_left_d = 4'd0;
               w_prog_in_d   = 1'b0;
            end
         end
         StLoad: begin
            if (r_bits_left != 4'd0) begin
               w_prog_in_d   = r_shift[0];
               w_prog_en_d   = 1'b1;
               w_load_en     = 1'b1;
               w_shift_d     = r_shift >> 1;
               w_bits_left_d = r_bits_left - 4'd1;
               w_bit_cnt_d   = r_bit_cnt + CNT_W'(1);
            end
            // A handshake on the last held bit refills the shifter with no bubble.
            if (w_hs) begin
               w_shift_d     = io_cfg.word_in;
               w_bits_left_d = 4'd8;
               w_word_cnt_d  = r_word_cnt + WC_W'(1);
            end
            if (w_bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
               w_state_d = StVerify;
            end
         end
         StVerify: begin
            w_recirc_d  = 1'b1;
            w_prog_en_d = 1'b1;
            // The first VERIFY cycle still carries the final load bit into the chain.
            if (r_recirc && r_prog_en) begin
               w_ver_en    = 1'b1;
               w_ver_cnt_d = r_ver_cnt + CNT_W'(1);
            end
            if (w_ver_cnt_d == CNT_W'(CHAIN_LEN)) begin
               w_state_d   = StDone;
               w_recirc_d  = 1'b0;
               w_prog_en_d = 1'b0;
            end
         end
         StDone: begin
            w_done_d  = 1'b1;
            w_error_d = r_error || (w_crc_ver != w_crc_load);
            w_state_d = StIdle;
         end
      endcase

      w_busy_d       = (w_state_d == StLoad) || (w_state_d == StVerify);
      w_bits_need    = CNT_W'(CHAIN_LEN) - w_bit_cnt_d;
      w_word_ready_d = (w_state_d == StLoad) && (w_bits_left_d <= 4'd1) &&
                       (w_bits_need > CNT_W'(w_bits_left_d)) &&
                       (w_word_cnt_d < WC_W'(NUM_WORDS));
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_shift      <= 8'h00;
         r_bits_left  <= 4'd0;
         r_bit_cnt    <= '0;
         r_ver_cnt    <= '0;
         r_word_cnt   <= '0;
         r_prog_in    <= 1'b0;
         r_prog_en    <= 1'b0;
         r_recirc     <= 1'b0;
         r_word_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_shift      <= w_shift_d;
         r_bits_left  <= w_bits_left_d;
         r_bit_cnt    <= w_bit_cnt_d;
         r_ver_cnt    <= w_ver_cnt_d;
         r_word_cnt   <= w_word_cnt_d;
         r_prog_in    <= w_prog_in_d;
         r_prog_en    <= w_prog_en_d;
         r_recirc     <= w_recirc_d;
         r_word_ready <= w_word_ready_d;
         r_busy       <= w_busy_d;
         r_done       <= w_done_d;
         r_error      <= w_error_d;
      end
   end

   crc8_serial u_crc_load (
      .prog_clk (prog_clk),
      .rst      (rst),
      .i_clr    (w_crc_clr),
      .i_en     (w_load_en),
      .i_bit    (r_shift[0]),
      .o_crc    (w_crc_load)
   );

   crc8_serial u_crc_ver (
      .prog_clk (prog_clk),
      .rst      (rst),
      .i_clr    (w_crc_clr),
      .i_en     (w_ver_en),
      .i_bit    (io_cfg.chain_out),
      .o_crc    (w_crc_ver)
   );

   assign io_cfg.prog_in    = r_recirc ? io_cfg.chain_out : r_prog_in;
   assign io_cfg.prog_en    = r_prog_en;
   assign io_cfg.word_ready = r_word_ready;
   assign io_cfg.busy       = r_busy;
   assign io_cfg.done       = r_done;
   assign io_cfg.error      = r_error;
   assign io_cfg.crc_out    = w_crc_load;

endmodule
